irb_frame_sink: RTL and testbench

Receiving end of the LCD controller's image-result-buffer (IRB) write stream. Captures one 64-pixel, 8-bit frame per write burst into a double-buffered 64×8 store. Swaps banks only when a frame arrives complete and in order, so downstream readers never see a torn image. Exposes a registered random-access read port, frame status, a running pixel checksum and a sequence-error flag for the display/processor side of the design.

---
 rtl/irb_frame_sink_if.sv | 31 +++
 rtl/irb_frame_sink.sv | 133 +++++++++++++
 tb/tb_irb_frame_sink.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/irb_frame_sink_if.sv
// IRB write stream plus the front-bank read/status side of the frame sink.
// The LCD controller side uses master; the sink uses slave.
interface irb_frame_sink_if #(
    parameter int DEPTH = 64,
    parameter int DW    = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH * ((1 << DW) - 1) + 1);

    logic          irb_rw;
    logic [AW-1:0] irb_a;
    logic [DW-1:0] irb_d;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          frame_valid;
    logic          frame_done;
    logic [7:0]    frame_cnt;
    logic [CW-1:0] checksum;
    logic          seq_err;
    logic          err_clr;

    modport master (
        output irb_rw, irb_a, irb_d, rd_addr, err_clr,
        input  rd_data, frame_valid, frame_done, frame_cnt, checksum, seq_err
    );

    modport slave (
        input  irb_rw, irb_a, irb_d, rd_addr, err_clr,
        output rd_data, frame_valid, frame_done, frame_cnt, checksum, seq_err
    );
endinterface

// File: rtl/irb_frame_sink.sv
// Double-buffered IRB frame capture: the back bank fills in address order and
// is swapped to the front only when pixel DEPTH-1 lands in sequence.
module irb_frame_sink #(
    parameter int DEPTH = 64,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    irb_frame_sink_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH * ((1 << DW) - 1) + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          front_sel;
    logic [AW-1:0] exp_a;
    logic [CW-1:0] acc;

    logic          start, advance, complete, err_set, we;

    logic [DW-1:0] rd_data;
    logic          frame_valid, frame_done, seq_err;
    logic [7:0]    frame_cnt;
    logic [CW-1:0] checksum;

    // Bank b occupies entries b*DEPTH .. b*DEPTH+DEPTH-1.
    logic [DW-1:0] mem [2*DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.irb_rw)
                    state_nxt = (bus.irb_a == '0) ? CAPTURE : HOLD;
            end
            CAPTURE: begin
                if (!bus.irb_rw)
                    state_nxt = IDLE;
                else if (bus.irb_a != exp_a || bus.irb_a == LAST)
                    state_nxt = HOLD;
            end
            HOLD: begin
                // The controller parks on the last address with the strobe
                // high; only a strobe drop re-arms capture.
                if (!bus.irb_rw) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start    = 1'b0;
        advance  = 1'b0;
        complete = 1'b0;
        err_set  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.irb_rw) begin
                    if (bus.irb_a == '0) start   = 1'b1;
                    else                 err_set = 1'b1;
                end
            end
            CAPTURE: begin
                if (!bus.irb_rw) begin
                    err_set = 1'b1;
                end else if (bus.irb_a == exp_a) begin
                    advance  = 1'b1;
                    complete = (bus.irb_a == LAST);
                end else begin
                    err_set = 1'b1;
                end
            end
            default: ;
        endcase
        we = start | advance;
    end

    always_ff @(posedge clk) begin
        if (we) mem[{~front_sel, bus.irb_a}] <= bus.irb_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_sel   <= 1'b0;
            exp_a       <= '0;
            acc         <= '0;
            rd_data     <= '0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            checksum    <= '0;
            seq_err     <= 1'b0;
        end else begin
            frame_done <= complete;
            if (start) begin
                exp_a <= AW'(1);
                acc   <= CW'(bus.irb_d);
            end else if (advance) begin
                exp_a <= exp_a + AW'(1);
                acc   <= acc + CW'(bus.irb_d);
            end
            if (complete) begin
                front_sel   <= ~front_sel;
                checksum    <= acc + CW'(bus.irb_d);
                frame_cnt   <= frame_cnt + 8'd1;
                frame_valid <= 1'b1;
            end
            // A new error outranks a simultaneous clear.
            if (err_set)          seq_err <= 1'b1;
            else if (bus.err_clr) seq_err <= 1'b0;
            rd_data <= mem[{front_sel, bus.rd_addr}];
        end
    end

    assign bus.rd_data     = rd_data;
    assign bus.frame_valid = frame_valid;
    assign bus.frame_done  = frame_done;
    assign bus.frame_cnt   = frame_cnt;
    assign bus.checksum    = checksum;
    assign bus.seq_err     = seq_err;
endmodule

// File: tb/tb_irb_frame_sink.sv
// Directed bench for irb_frame_sink: a vector table for the first frame, then
// hand-written sequences for swaps, errors, resets and counter wrap.
module tb_irb_frame_sink;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   done_seen;

    always #5 clk = ~clk;

    irb_frame_sink_if #(.DEPTH(64), .DW(8)) bus ();

    irb_frame_sink #(.DEPTH(64), .DW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       rw;
        logic [5:0] a;
        logic [7:0] d;
        logic [5:0] ra;
        logic       clr;
        logic       chk_rd;
        logic [7:0] e_rd;
        logic       e_done;
        logic       e_valid;
        logic [7:0] e_cnt;
        logic [13:0] e_sum;
        logic       e_err;
    } vec_t;

    vec_t tbl [69];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input logic rw, input logic [5:0] a, input logic [7:0] d,
                        input logic [5:0] ra, input logic clr);
        bus.irb_rw  = rw;
        bus.irb_a   = a;
        bus.irb_d   = d;
        bus.rd_addr = ra;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int mode, input int a);
        case (mode)
            0:       return 8'(a);
            1:       return 8'(3 * a);
            2:       return 8'd255;
            default: return 8'(2 * a);
        endcase
    endfunction

    // One in-order frame, hold cycles parked on 63, then one idle cycle.
    task automatic send_frame(input int mode, input logic [5:0] ra, input int hold);
        done_seen = 0;
        for (int a = 0; a < 64; a++) begin
            tick(1'b1, 6'(a), pix(mode, a), ra, 1'b0);
            if (bus.frame_done === 1'b1) done_seen++;
        end
        for (int h = 0; h < hold; h++) begin
            tick(1'b1, 6'd63, pix(mode, 63), ra, 1'b0);
            if (bus.frame_done === 1'b1) done_seen++;
        end
        tick(1'b0, 6'd63, 8'd0, ra, 1'b0);
        if (bus.frame_done === 1'b1) done_seen++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rd_data"},     32'(bus.rd_data),     32'd0);
        chk({tag, " frame_valid"}, 32'(bus.frame_valid), 32'd0);
        chk({tag, " frame_done"},  32'(bus.frame_done),  32'd0);
        chk({tag, " frame_cnt"},   32'(bus.frame_cnt),   32'd0);
        chk({tag, " checksum"},    32'(bus.checksum),    32'd0);
        chk({tag, " seq_err"},     32'(bus.seq_err),     32'd0);
    endtask

    initial begin
        // Frame 1 (d=3A), then four parked writes at 63, then strobe drop.
        for (int i = 0; i < 64; i++)
            tbl[i] = '{1'b1, 6'(i), 8'(3 * i), 6'd10, 1'b0, 1'b0, 8'd0,
                       (i == 63), (i == 63), 8'((i == 63) ? 1 : 0),
                       14'((i == 63) ? 6048 : 0), 1'b0};
        for (int i = 64; i < 68; i++)
            tbl[i] = '{1'b1, 6'd63, 8'd189, 6'd10, 1'b0, 1'b1, 8'd30,
                       1'b0, 1'b1, 8'd1, 14'd6048, 1'b0};
        tbl[68] = '{1'b0, 6'd63, 8'd0, 6'd10, 1'b0, 1'b1, 8'd30,
                    1'b0, 1'b1, 8'd1, 14'd6048, 1'b0};

        reset = 1'b1;
        bus.irb_rw = 1'b0; bus.irb_a = '0; bus.irb_d = '0;
        bus.rd_addr = '0;  bus.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        tick(1'b0, 6'd0, 8'd0, 6'd10, 1'b0);

        for (int i = 0; i < 69; i++) begin
            tick(tbl[i].rw, tbl[i].a, tbl[i].d, tbl[i].ra, tbl[i].clr);
            chk($sformatf("vec%0d frame_done", i),  32'(bus.frame_done),  32'(tbl[i].e_done));
            chk($sformatf("vec%0d frame_valid", i), 32'(bus.frame_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d frame_cnt", i),   32'(bus.frame_cnt),   32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d checksum", i),    32'(bus.checksum),    32'(tbl[i].e_sum));
            chk($sformatf("vec%0d seq_err", i),     32'(bus.seq_err),     32'(tbl[i].e_err));
            if (tbl[i].chk_rd)
                chk($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(tbl[i].e_rd));
        end

        // Frame 2 all 255 while polling addr 5: old 15 until the swap.
        for (int a = 0; a < 64; a++) begin
            tick(1'b1, 6'(a), 8'd255, 6'd5, 1'b0);
            chk($sformatf("f2 rd_data a%0d", a), 32'(bus.rd_data), 32'd15);
        end
        chk("f2 frame_done", 32'(bus.frame_done), 32'd1);
        chk("f2 checksum",   32'(bus.checksum),   32'd16320);
        chk("f2 frame_cnt",  32'(bus.frame_cnt),  32'd2);
        tick(1'b1, 6'd63, 8'd255, 6'd5, 1'b0);
        chk("f2 rd_data new",    32'(bus.rd_data),    32'd255);
        chk("f2 done one cycle", 32'(bus.frame_done), 32'd0);
        tick(1'b0, 6'd63, 8'd0, 6'd5, 1'b0);

        // Address skip 19 -> 21.
        for (int a = 0; a < 20; a++) tick(1'b1, 6'(a), 8'd7, 6'd5, 1'b0);
        chk("skip seq_err before", 32'(bus.seq_err), 32'd0);
        tick(1'b1, 6'd21, 8'd7, 6'd5, 1'b0);
        chk("skip seq_err", 32'(bus.seq_err), 32'd1);
        done_seen = 0;
        for (int a = 22; a < 64; a++) begin
            tick(1'b1, 6'(a), 8'd7, 6'd5, 1'b0);
            if (bus.frame_done === 1'b1) done_seen++;
        end
        tick(1'b0, 6'd0, 8'd0, 6'd5, 1'b0);
        chk("skip no done",   32'(done_seen),       32'd0);
        chk("skip frame_cnt", 32'(bus.frame_cnt),   32'd2);
        chk("skip checksum",  32'(bus.checksum),    32'd16320);
        chk("skip old data",  32'(bus.rd_data),     32'd255);
        tick(1'b0, 6'd0, 8'd0, 6'd5, 1'b1);
        chk("skip err_clr", 32'(bus.seq_err), 32'd0);

        // Asynchronous reset in the middle of a frame.
        for (int a = 0; a <= 30; a++) tick(1'b1, 6'(a), 8'd9, 6'd5, 1'b0);
        reset = 1'b1;
        #2;
        chk_all_zero("midreset");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        tick(1'b0, 6'd0, 8'd0, 6'd7, 1'b0);
        send_frame(0, 6'd7, 1);
        chk("post-reset done count", 32'(done_seen),       32'd1);
        chk("post-reset frame_cnt",  32'(bus.frame_cnt),   32'd1);
        chk("post-reset checksum",   32'(bus.checksum),    32'd2016);
        chk("post-reset valid",      32'(bus.frame_valid), 32'd1);
        chk("post-reset rd_data",    32'(bus.rd_data),     32'd7);

        // 256 back-to-back frames from reset: counter wraps to 0.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tick(1'b0, 6'd0, 8'd0, 6'd7, 1'b0);
        for (int f = 0; f < 256; f++) begin
            send_frame(0, 6'd7, 0);
            if (f == 0)   chk("wrap first done", 32'(done_seen), 32'd1);
            if (f == 254) chk("wrap cnt 255", 32'(bus.frame_cnt), 32'd255);
        end
        chk("wrap frame_cnt", 32'(bus.frame_cnt),   32'd0);
        chk("wrap valid",     32'(bus.frame_valid), 32'd1);
        chk("wrap checksum",  32'(bus.checksum),    32'd2016);
        chk("wrap seq_err",   32'(bus.seq_err),     32'd0);
        tick(1'b1, 6'd5, 8'd0, 6'd7, 1'b1);
        chk("err beats clr", 32'(bus.seq_err), 32'd1);
        tick(1'b1, 6'd6, 8'd0, 6'd7, 1'b0);
        tick(1'b0, 6'd0, 8'd0, 6'd7, 1'b1);
        chk("clr after err", 32'(bus.seq_err), 32'd0);

        // Strobe drop at A=40, fresh frame right after.
        for (int a = 0; a < 40; a++) tick(1'b1, 6'(a), 8'd1, 6'd63, 1'b0);
        chk("abort seq_err before", 32'(bus.seq_err), 32'd0);
        tick(1'b0, 6'd40, 8'd0, 6'd63, 1'b0);
        chk("abort seq_err",   32'(bus.seq_err),    32'd1);
        chk("abort frame_cnt", 32'(bus.frame_cnt),  32'd0);
        chk("abort checksum",  32'(bus.checksum),   32'd2016);
        send_frame(3, 6'd63, 0);
        chk("fresh done count", 32'(done_seen),     32'd1);
        chk("fresh frame_cnt",  32'(bus.frame_cnt), 32'd1);
        chk("fresh checksum",   32'(bus.checksum),  32'd4032);
        chk("fresh rd_data",    32'(bus.rd_data),   32'd126);
        chk("fresh seq_err",    32'(bus.seq_err),   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
